// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front end for the on-chip 32-bit block RAM: zero-wait reads/writes,
// two-cycle ERROR response for misaligned, oversize or write-protected transfers.
module ahb_bram_ctrl #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   input  logic                  WPROT,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
   output logic [31:0]           BRAM_DINA,
   output logic [3:0]            BRAM_WEA,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
   input  logic [31:0]           BRAM_DOUTB
);

   // state   | meaning
   // IDLE_OK | OKAY response, ready; legal data phase (if any) in progress
   // ERR1    | first ERROR cycle, HREADYOUT low
   // ERR2    | second ERROR cycle, HREADYOUT high; next address phase sampled
   typedef enum logic [1:0] {IDLE_OK, ERR1, ERR2} state_t;

   state_t                state;
   logic                  accept;
   logic                  illegal;
   logic [3:0]            mask_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            mask_q;
   logic                  wr_q;
   logic                  rd_q;
   logic                  unused_ok;

   assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

   // ERR1 drives HREADY low on the bus; gating here keeps a misbehaving master out too
   assign accept = HSEL & HTRANS[1] & HREADY & (state != ERR1);

   assign illegal = (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                  | (HWRITE & WPROT);

   always_comb begin
      mask_d = 4'b1111;
      case (HSIZE)
         3'd0:    mask_d = 4'b0001 << HADDR[1:0];
         3'd1:    mask_d = HADDR[1] ? 4'b1100 : 4'b0011;
         default: mask_d = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= IDLE_OK;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         addr_q    <= '0;
         mask_q    <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
      end else begin
         wr_q <= accept & ~illegal & HWRITE;
         rd_q <= accept & ~illegal & ~HWRITE;
         if (accept) begin
            addr_q <= HADDR[ADDR_WIDTH+1:2];
            mask_q <= mask_d;
         end
         case (state)
            ERR1: begin
               state     <= ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
            default: begin
               if (accept & illegal) begin
                  state     <= ERR1;
                  HREADYOUT <= 1'b0;
                  HRESP     <= 1'b1;
               end else begin
                  state     <= IDLE_OK;
                  HREADYOUT <= 1'b1;
                  HRESP     <= 1'b0;
               end
            end
         endcase
      end
   end

   // wr_q is cleared asynchronously by reset, so a pending write is dropped at once
   assign BRAM_WEA   = (wr_q && state == IDLE_OK) ? mask_q : 4'b0000;
   assign BRAM_ADDRA = addr_q;
   assign BRAM_DINA  = HWDATA;
   assign BRAM_ADDRB = HADDR[ADDR_WIDTH+1:2];
   assign HRDATA     = rd_q ? BRAM_DOUTB : 32'h0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: directed bus scenarios plus random transfers checked
// against a byte-array memory model with transfer-level response rules.
module tb_ahb_bram_ctrl;
   localparam int AW = 14;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic          HWRITE;
   logic          HREADY;
   logic [31:0]   HWDATA;
   logic          WPROT;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic [AW-1:0] BRAM_ADDRA;
   logic [31:0]   BRAM_DINA;
   logic [3:0]    BRAM_WEA;
   logic [AW-1:0] BRAM_ADDRB;
   logic [31:0]   BRAM_DOUTB;

   ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .WPROT(WPROT),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .BRAM_ADDRA(BRAM_ADDRA), .BRAM_DINA(BRAM_DINA), .BRAM_WEA(BRAM_WEA),
      .BRAM_ADDRB(BRAM_ADDRB), .BRAM_DOUTB(BRAM_DOUTB)
   );

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Write-first block RAM attached to the controller
   logic [31:0] ram [0:(1<<AW)-1];
   always @(posedge HCLK) begin
      if (|BRAM_WEA) ram[BRAM_ADDRA] <= merge(ram[BRAM_ADDRA], BRAM_DINA, BRAM_WEA);
      BRAM_DOUTB <= (|BRAM_WEA && BRAM_ADDRA == BRAM_ADDRB)
                    ? merge(ram[BRAM_ADDRB], BRAM_DINA, BRAM_WEA) : ram[BRAM_ADDRB];
   end

   // Reference: byte-addressed memory and the transfer whose data phase is pending
   logic [7:0] ref_mem [0:(4<<AW)-1];
   typedef enum {K_NONE, K_WR, K_RD, K_ERR} kind_t;
   kind_t       p_kind;
   logic [31:0] p_addr;
   logic [31:0] p_wdata;
   logic [3:0]  p_mask;
   logic [31:0] last_rdata;
   logic [3:0]  last_wea;
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b;
      b = int'(a[AW+1:0]) & ~3;
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_prev(input bit err2);
      int b;
      case (p_kind)
         K_NONE: begin
            chk("idle_ready", 32'(HREADYOUT), 32'd1);
            chk("idle_resp",  32'(HRESP), 32'd0);
            chk("idle_wea",   32'(BRAM_WEA), 32'd0);
            chk("idle_rdata", HRDATA, 32'd0);
         end
         K_WR: begin
            chk("wr_ready", 32'(HREADYOUT), 32'd1);
            chk("wr_resp",  32'(HRESP), 32'd0);
            chk("wr_wea",   32'(BRAM_WEA), 32'(p_mask));
            chk("wr_addra", 32'(BRAM_ADDRA), 32'(p_addr[AW+1:2]));
            chk("wr_dina",  BRAM_DINA, p_wdata);
            chk("wr_rdata", HRDATA, 32'd0);
            last_wea = BRAM_WEA;
            b = int'(p_addr[AW+1:0]) & ~3;
            for (int i = 0; i < 4; i++) if (p_mask[i]) ref_mem[b+i] = p_wdata[8*i +: 8];
         end
         K_RD: begin
            chk("rd_ready", 32'(HREADYOUT), 32'd1);
            chk("rd_resp",  32'(HRESP), 32'd0);
            chk("rd_wea",   32'(BRAM_WEA), 32'd0);
            chk("rd_data",  HRDATA, ref_word(p_addr));
            last_rdata = HRDATA;
         end
         default: begin
            chk(err2 ? "err2_ready" : "err1_ready", 32'(HREADYOUT), 32'(err2));
            chk("err_resp",  32'(HRESP), 32'd1);
            chk("err_wea",   32'(BRAM_WEA), 32'd0);
            chk("err_rdata", HRDATA, 32'd0);
         end
      endcase
   endtask

   // One address phase; checks the data phase of the previous transfer alongside it
   task automatic xfer(input bit sel, input bit [1:0] trans, input bit wr, input bit [2:0] size,
                       input bit [31:0] addr, input bit [31:0] wdata, input bit wp);
      bit active;
      bit legal;
      int nb;
      @(negedge HCLK);
      HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; WPROT = wp;
      HWDATA = p_wdata;
      #1 check_prev(1'b0);
      if (p_kind == K_ERR) begin
         @(negedge HCLK);
         #1 check_prev(1'b1);
      end
      active = sel && trans[1];
      legal  = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0) && !(wr && wp);
      if (!active)     p_kind = K_NONE;
      else if (!legal) p_kind = K_ERR;
      else             p_kind = wr ? K_WR : K_RD;
      nb = (size <= 3'd2) ? (1 << size) : 4;
      p_mask  = 4'(((1 << nb) - 1) << addr[1:0]);
      p_addr  = addr;
      p_wdata = wdata;
   endtask

   task automatic idle();
      xfer(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, $urandom, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
      for (int i = 0; i < (4<<AW); i++) ref_mem[i] = 8'h0;
      p_kind = K_NONE; p_addr = 0; p_wdata = 0; p_mask = 0;
      last_rdata = 0; last_wea = 0;
      HRESET = 1'b1; HSEL = 0; HADDR = 0; HTRANS = 0; HSIZE = 0; HWRITE = 0;
      HWDATA = 32'h1357_9BDF; WPROT = 0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_ready", 32'(HREADYOUT), 32'd1);
      chk("rst_resp",  32'(HRESP), 32'd0);
      chk("rst_rdata", HRDATA, 32'd0);
      chk("rst_wea",   32'(BRAM_WEA), 32'd0);
      chk("rst_addra", 32'(BRAM_ADDRA), 32'd0);
      chk("rst_dina",  BRAM_DINA, 32'h1357_9BDF);
      HRESET = 1'b0;

      // word write then word read
      xfer(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
      xfer(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
      chk("t1_wea", 32'(last_wea), 32'hF);
      idle();
      chk("t1_rdata", last_rdata, 32'hDEADBEEF);

      // byte writes then word read
      xfer(1, 2'b10, 1, 3'd0, 32'h21, 32'h0000_1100, 0);
      xfer(1, 2'b11, 1, 3'd0, 32'h22, 32'h0022_0000, 0);
      chk("t2_wea1", 32'(last_wea), 32'h2);
      xfer(1, 2'b10, 0, 3'd2, 32'h20, 32'h0, 0);
      chk("t2_wea2", 32'(last_wea), 32'h4);
      idle();
      chk("t2_rdata", last_rdata, 32'h0022_1100);

      // write immediately followed by read of the same word
      xfer(1, 2'b10, 1, 3'd2, 32'h40, 32'hCAFEF00D, 0);
      xfer(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 0);
      idle();
      chk("t3_rdata", last_rdata, 32'hCAFEF00D);

      // misaligned halfword write, misaligned word read, then check word 0 untouched
      xfer(1, 2'b10, 1, 3'd1, 32'h03, 32'hFFFF_FFFF, 0);
      xfer(1, 2'b10, 0, 3'd2, 32'h06, 32'h0, 0);
      xfer(1, 2'b10, 0, 3'd2, 32'h00, 32'h0, 0);
      idle();
      chk("t4_rdata", last_rdata, 32'h0);

      // write protect
      xfer(1, 2'b10, 1, 3'd2, 32'h80, 32'h0BADF00D, 0);
      xfer(1, 2'b10, 1, 3'd2, 32'h80, 32'h12345678, 1);
      xfer(1, 2'b10, 0, 3'd2, 32'h80, 32'h0, 1);
      idle();
      chk("t5_rdata", last_rdata, 32'h0BADF00D);

      // reset during the data phase of a word write
      xfer(1, 2'b10, 1, 3'd2, 32'h100, 32'hA5A5A5A5, 0);
      @(negedge HCLK);
      HSEL = 0; HTRANS = 2'b00; HWDATA = p_wdata;
      #1 chk("t6_pre_wea", 32'(BRAM_WEA), 32'hF);
      HRESET = 1'b1;
      #1;
      chk("t6_wea",   32'(BRAM_WEA), 32'd0);
      chk("t6_ready", 32'(HREADYOUT), 32'd1);
      chk("t6_resp",  32'(HRESP), 32'd0);
      @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;
      p_kind = K_NONE;
      xfer(1, 2'b10, 0, 3'd2, 32'h100, 32'h0, 0);
      idle();
      chk("t6_rdata", last_rdata, 32'h0);

      // random traffic over a few aliased words
      for (int n = 0; n < 300; n++) begin
         automatic int r = $urandom_range(0, 9);
         automatic bit [2:0] sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
         automatic bit [31:0] a = ($urandom & 32'hFFFF_0000) | (32'h200 + $urandom_range(0, 31));
         xfer(($urandom % 8) != 0, 2'($urandom), 1'($urandom), sz, a, $urandom,
              $urandom_range(0, 6) == 0);
      end
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
